// File: rtl/pull_slice_fifo.sv
// Pull-channel bit-slice stage with a DEPTH-entry prefetch FIFO.
// The fetch FSM pulls words from the producer whenever there is room.
// Only the slice inp_0d[LSB+OUT_W-1:LSB] is stored.
// The serve FSM answers consumer pulls from the FIFO head.
// Both sides use 4-phase request/acknowledge handshakes with registered outputs.
module pull_slice_fifo #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    parameter int LSB   = 2,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             out_0r,
    output logic             out_0a,
    output logic [OUT_W-1:0] out_0d,
    output logic             inp_0r,
    input  logic             inp_0a,
    input  logic [IN_W-1:0]  inp_0d,
    output logic [LW-1:0]    level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (LSB + OUT_W > IN_W || DEPTH < 1) begin : g_bad_params
            $error("pull_slice_fifo: slice exceeds IN_W or DEPTH < 1");
        end
    endgenerate

    typedef enum logic [1:0] {I_IDLE, I_REQ, I_RTZ} fetch_state_t;
    typedef enum logic {O_IDLE, O_ACK} serve_state_t;

    fetch_state_t fetch_state, fetch_next;
    serve_state_t serve_state, serve_next;

    logic             inp_r_next;
    logic             out_a_next;
    logic             push;
    logic             pop;
    logic             commit;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OUT_W-1:0] mem [DEPTH];

    // Producer bits outside the slice are dropped on purpose; folding them into
    // one ignored net keeps the whole input port visibly consumed.
    logic unused_inp_bits;
    assign unused_inp_bits = ^inp_0d;

    // Fetch state register and the registered producer request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_state <= I_IDLE;
            inp_0r      <= 1'b0;
        end else begin
            fetch_state <= fetch_next;
            inp_0r      <= inp_r_next;
        end
    end

    // Fetch next state: request only when a slot is free, then run the 4-phase cycle.
    always_comb begin
        fetch_next = fetch_state;
        case (fetch_state)
            I_IDLE:  if (level < LW'(DEPTH)) fetch_next = I_REQ;
            I_REQ:   if (inp_0a)             fetch_next = I_RTZ;
            I_RTZ:   if (!inp_0a)            fetch_next = I_IDLE;
            default:                         fetch_next = I_IDLE;
        endcase
    end

    // Fetch outputs: the request is high exactly while the next state is I_REQ.
    always_comb begin
        push       = (fetch_state == I_REQ) && inp_0a;
        inp_r_next = (fetch_next == I_REQ);
    end

    // Serve state register, registered acknowledge, and the data register loaded on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            serve_state <= O_IDLE;
            out_0a      <= 1'b0;
            out_0d      <= '0;
        end else begin
            serve_state <= serve_next;
            out_0a      <= out_a_next;
            if (pop) out_0d <= mem[rd_ptr];
        end
    end

    // Serve next state: answer a pull only when a committed word is available.
    always_comb begin
        serve_next = serve_state;
        case (serve_state)
            O_IDLE:  if (out_0r && level != '0) serve_next = O_ACK;
            O_ACK:   if (!out_0r)               serve_next = O_IDLE;
            default:                            serve_next = O_IDLE;
        endcase
    end

    // Serve outputs: pop on the O_IDLE to O_ACK transition; ack high while in O_ACK.
    always_comb begin
        pop        = (serve_state == O_IDLE) && out_0r && (level != '0);
        out_a_next = (serve_next == O_ACK);
    end

    // FIFO storage and pointers.
    // A word is written at the write pointer on the ack edge and is counted in
    // level one edge later, so the serve side sees it two edges after the ack.
    // Pointers wrap explicitly so any DEPTH works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            commit <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            commit <= push;
            if (push) begin
                mem[wr_ptr] <= inp_0d[LSB+OUT_W-1:LSB];
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({commit, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_pull_slice_fifo.sv
// Directed bench for pull_slice_fifo.
// Index 0 of each signal array drives a DEPTH=4 instance.
// Index 1 drives a DEPTH=3 instance, which exercises non-power-of-2 pointer wrap.
// Expected slices go into a scoreboard queue when the producer acks.
// They are popped and compared when the consumer sees out_0a.
module tb_pull_slice_fifo;

    logic        clk;
    logic        rst_n;
    logic        out_0r_s [2];
    logic        out_0a_s [2];
    logic [15:0] out_0d_s [2];
    logic        inp_0r_s [2];
    logic        inp_0a_s [2];
    logic [17:0] inp_0d_s [2];
    logic [2:0]  level0;
    logic [1:0]  level1;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb [$];

    pull_slice_fifo #(.IN_W(18), .OUT_W(16), .LSB(2), .DEPTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .out_0r (out_0r_s[0]),
        .out_0a (out_0a_s[0]),
        .out_0d (out_0d_s[0]),
        .inp_0r (inp_0r_s[0]),
        .inp_0a (inp_0a_s[0]),
        .inp_0d (inp_0d_s[0]),
        .level  (level0)
    );

    pull_slice_fifo #(.IN_W(18), .OUT_W(16), .LSB(2), .DEPTH(3)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .out_0r (out_0r_s[1]),
        .out_0a (out_0a_s[1]),
        .out_0d (out_0d_s[1]),
        .inp_0r (inp_0r_s[1]),
        .inp_0a (inp_0a_s[1]),
        .inp_0d (inp_0d_s[1]),
        .level  (level1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic get_sig(input int w, input int id);
        return (id == 0) ? inp_0r_s[w] : out_0a_s[w];
    endfunction

    function automatic logic [31:0] get_level(input int w);
        return (w == 0) ? 32'(level0) : 32'(level1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) at negedges for inp_0r (id 0) or out_0a (id 1) to reach val.
    task automatic wait_for(input int w, input int id, input logic val, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (get_sig(w, id) === val) break;
            @(negedge clk);
        end
        checkOutput(tag, 32'(get_sig(w, id)), 32'(val));
    endtask

    // Producer side: supply one word through a full 4-phase handshake.
    task automatic applyStimulus(input int w, input logic [17:0] data);
        wait_for(w, 0, 1'b1, "prod_req_up");
        inp_0a_s[w] = 1'b1;
        inp_0d_s[w] = data;
        sb.push_back(data[17:2]);
        @(negedge clk);
        wait_for(w, 0, 1'b0, "prod_req_down");
        inp_0a_s[w] = 1'b0;
        @(negedge clk);
    endtask

    // Consumer side: one complete pull, comparing the data against the scoreboard.
    task automatic pull_word(input int w);
        logic [15:0] exp;
        out_0r_s[w] = 1'b1;
        @(negedge clk);
        wait_for(w, 1, 1'b1, "pull_ack_up");
        exp = 16'hxxxx;
        if (sb.size() > 0) exp = sb.pop_front();
        checkOutput("pull_data", 32'(out_0d_s[w]), 32'(exp));
        out_0r_s[w] = 1'b0;
        @(negedge clk);
        wait_for(w, 1, 1'b0, "pull_ack_down");
    endtask

    // At level 2: the ack edge t writes a word, and its commit at t+1 coincides with a pop.
    task automatic simul_step(input int w, input logic [17:0] data);
        logic [15:0] exp;
        wait_for(w, 0, 1'b1, "sim_req_up");
        checkOutput("sim_level_before", get_level(w), 32'd2);
        inp_0a_s[w] = 1'b1;
        inp_0d_s[w] = data;
        sb.push_back(data[17:2]);
        @(negedge clk);
        checkOutput("sim_level_mid", get_level(w), 32'd2);
        inp_0a_s[w] = 1'b0;
        out_0r_s[w] = 1'b1;
        @(negedge clk);
        checkOutput("sim_level_after", get_level(w), 32'd2);
        checkOutput("sim_ack", 32'(out_0a_s[w]), 32'd1);
        exp = 16'hxxxx;
        if (sb.size() > 0) exp = sb.pop_front();
        checkOutput("sim_data", 32'(out_0d_s[w]), 32'(exp));
        out_0r_s[w] = 1'b0;
        @(negedge clk);
        wait_for(w, 1, 1'b0, "sim_ack_down");
    endtask

    // Directed sequence.
    initial begin
        logic [15:0] exp;
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            out_0r_s[w] = 1'b0;
            inp_0a_s[w] = 1'b0;
            inp_0d_s[w] = '0;
        end

        // Reset values, then the first request one edge after release.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_inp_0r", 32'(inp_0r_s[0]), 32'd0);
        checkOutput("rst_out_0a", 32'(out_0a_s[0]), 32'd0);
        checkOutput("rst_out_0d", 32'(out_0d_s[0]), 32'd0);
        checkOutput("rst_level", get_level(0), 32'd0);
        checkOutput("rst_level_d3", get_level(1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_req", 32'(inp_0r_s[0]), 32'd1);

        // One word through both handshakes.
        applyStimulus(0, 18'h2ABCD);
        pull_word(0);
        checkOutput("single_level", get_level(0), 32'd0);

        // Fill to full with the consumer idle, then drain in order.
        applyStimulus(0, 18'h00004);
        applyStimulus(0, 18'h00008);
        applyStimulus(0, 18'h0000C);
        applyStimulus(0, 18'h00010);
        checkOutput("full_level", get_level(0), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("full_no_req", 32'(inp_0r_s[0]), 32'd0);
        end
        pull_word(0);
        wait_for(0, 0, 1'b1, "full_req_after_pop");
        pull_word(0);
        pull_word(0);
        pull_word(0);
        checkOutput("drained_level", get_level(0), 32'd0);

        // Empty FIFO with a pending pull: no ack; ack edge t gives out_0a at t+2.
        out_0r_s[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("empty_no_ack", 32'(out_0a_s[0]), 32'd0);
        end
        wait_for(0, 0, 1'b1, "lat_req_up");
        inp_0a_s[0] = 1'b1;
        inp_0d_s[0] = 18'h30003;
        sb.push_back(16'hC000);
        @(negedge clk);
        checkOutput("lat_edge_t", 32'(out_0a_s[0]), 32'd0);
        inp_0a_s[0] = 1'b0;
        @(negedge clk);
        checkOutput("lat_edge_t1", 32'(out_0a_s[0]), 32'd0);
        @(negedge clk);
        checkOutput("lat_edge_t2", 32'(out_0a_s[0]), 32'd1);
        exp = 16'hxxxx;
        if (sb.size() > 0) exp = sb.pop_front();
        checkOutput("lat_data", 32'(out_0d_s[0]), 32'(exp));
        out_0r_s[0] = 1'b0;
        @(negedge clk);
        wait_for(0, 1, 1'b0, "lat_ack_down");

        // Simultaneous push/pop at level 2 on DEPTH=4.
        applyStimulus(0, 18'h1F00F);
        applyStimulus(0, 18'h0A5A6);
        simul_step(0, 18'h3C3C1);
        pull_word(0);
        pull_word(0);

        // Same on DEPTH=3 across 10 words so both pointers wrap several times.
        applyStimulus(1, 18'($urandom));
        applyStimulus(1, 18'($urandom));
        for (int i = 0; i < 8; i++) simul_step(1, 18'($urandom));
        pull_word(1);
        pull_word(1);
        checkOutput("wrap_level", get_level(1), 32'd0);

        // Asynchronous reset in the middle of both handshakes.
        applyStimulus(0, 18'h15555);
        out_0r_s[0] = 1'b1;
        @(negedge clk);
        checkOutput("pre_rst_ack", 32'(out_0a_s[0]), 32'd1);
        checkOutput("pre_rst_req", 32'(inp_0r_s[0]), 32'd1);
        exp = 16'hxxxx;
        if (sb.size() > 0) exp = sb.pop_front();
        checkOutput("pre_rst_data", 32'(out_0d_s[0]), 32'(exp));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ack", 32'(out_0a_s[0]), 32'd0);
        checkOutput("async_rst_req", 32'(inp_0r_s[0]), 32'd0);
        checkOutput("async_rst_level", get_level(0), 32'd0);
        checkOutput("async_rst_data", 32'(out_0d_s[0]), 32'd0);
        out_0r_s[0] = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_req", 32'(inp_0r_s[0]), 32'd1);
        checkOutput("restart_level", get_level(0), 32'd0);
        applyStimulus(0, 18'h2468C);
        pull_word(0);

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
